// File: rtl/jtag_axi_tap_ctrl.sv
// IEEE 1149.1 TAP controller with IR, IDCODE/BYPASS DRs and user DR select decode.
// User DRs receive capture/shift/update strobes and a one-hot select; they hold no TAP state.
package jtag_axi_tap_ctrl_pkg;
  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'h0,
    RUN_TEST_IDLE    = 4'h1,
    SELECT_DR_SCAN   = 4'h2,
    CAPTURE_DR       = 4'h3,
    SHIFT_DR         = 4'h4,
    EXIT1_DR         = 4'h5,
    PAUSE_DR         = 4'h6,
    EXIT2_DR         = 4'h7,
    UPDATE_DR        = 4'h8,
    SELECT_IR_SCAN   = 4'h9,
    CAPTURE_IR       = 4'hA,
    SHIFT_IR         = 4'hB,
    EXIT1_IR         = 4'hC,
    PAUSE_IR         = 4'hD,
    EXIT2_IR         = 4'hE,
    UPDATE_IR        = 4'hF
  } tap_ctrl_fsm_t;
endpackage

module jtag_axi_tap_ctrl
  import jtag_axi_tap_ctrl_pkg::*;
#(
  parameter int unsigned          IR_WIDTH     = 4,
  parameter logic [31:0]          IDCODE_VAL   = 32'h1000_0001,
  parameter logic [IR_WIDTH-1:0]  IR_IDCODE    = 'h1,
  parameter logic [IR_WIDTH-1:0]  IR_BYPASS    = '1,
  parameter int unsigned          N_USER       = 2,
  parameter logic [IR_WIDTH-1:0]  USER_IR_BASE = 'h2
) (
  input  logic                tck,
  input  logic                trst,
  input  logic                tms,
  input  logic                tdi,
  output logic                tdo,
  output logic                tdo_en,
  output tap_ctrl_fsm_t       tap_state,
  output logic [IR_WIDTH-1:0] ir_o,
  output logic [N_USER-1:0]   user_sel,
  output logic                capture_dr,
  output logic                shift_dr,
  output logic                update_dr,
  input  logic [N_USER-1:0]   user_tdo
);

  tap_ctrl_fsm_t       state, state_nxt;
  logic [IR_WIDTH-1:0] ir_sr;
  logic [31:0]         idcode_sr;
  logic                bypass_ff;
  logic                is_bypass_op, sel_idcode, sel_bypass, user_tdo_mux;

  always_comb begin
    state_nxt = state;
    unique case (state)
      TEST_LOGIC_RESET: state_nxt = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    state_nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   state_nxt = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       state_nxt = tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         state_nxt = tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         state_nxt = tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         state_nxt = tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         state_nxt = tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        state_nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   state_nxt = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       state_nxt = tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         state_nxt = tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         state_nxt = tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         state_nxt = tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         state_nxt = tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        state_nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      default:          state_nxt = TEST_LOGIC_RESET;
    endcase
  end

  always_ff @(posedge tck or posedge trst) begin
    if (trst) state <= TEST_LOGIC_RESET;
    else      state <= state_nxt;
  end

  // BYPASS opcode wins over any overlapping IDCODE/user opcode.
  always_comb begin
    is_bypass_op = (ir_o == IR_BYPASS);
    sel_idcode   = (ir_o == IR_IDCODE) && !is_bypass_op;
    user_sel     = '0;
    user_tdo_mux = 1'b0;
    for (int unsigned k = 0; k < N_USER; k++) begin
      if (!is_bypass_op && !sel_idcode &&
          ({1'b0, ir_o} == {1'b0, USER_IR_BASE} + (IR_WIDTH+1)'(k))) begin
        user_sel[k]  = 1'b1;
        user_tdo_mux = user_tdo[k];
      end
    end
    sel_bypass = !sel_idcode && (user_sel == '0);
  end

  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      ir_sr     <= IR_WIDTH'(1);
      ir_o      <= IR_IDCODE;
      idcode_sr <= IDCODE_VAL;
      bypass_ff <= 1'b0;
    end else begin
      unique case (state)
        CAPTURE_IR: ir_sr <= IR_WIDTH'(1);
        SHIFT_IR:   ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]};
        CAPTURE_DR: begin
          if (sel_idcode) idcode_sr <= IDCODE_VAL;
          if (sel_bypass) bypass_ff <= 1'b0;
        end
        SHIFT_DR: begin
          if (sel_idcode) idcode_sr <= {tdi, idcode_sr[31:1]};
          if (sel_bypass) bypass_ff <= tdi;
        end
        default: ;
      endcase
      // Reload on entry to TEST_LOGIC_RESET so the five-tms=1 escape lands with IDCODE active.
      if (state_nxt == TEST_LOGIC_RESET) ir_o <= IR_IDCODE;
      else if (state == UPDATE_IR)       ir_o <= ir_sr;
    end
  end

  always_comb begin
    tdo = 1'b0;
    if (state == SHIFT_IR) tdo = ir_sr[0];
    else if (state == SHIFT_DR) begin
      if (sel_idcode)      tdo = idcode_sr[0];
      else if (sel_bypass) tdo = bypass_ff;
      else                 tdo = user_tdo_mux;
    end
  end

  assign tap_state  = state;
  assign tdo_en     = (state == SHIFT_DR) || (state == SHIFT_IR);
  assign capture_dr = (state == CAPTURE_DR);
  assign shift_dr   = (state == SHIFT_DR);
  assign update_dr  = (state == UPDATE_DR);

endmodule

// File: doc/jtag_axi_tap_ctrl.md
# jtag_axi_tap_ctrl

Parametrised JTAG TAP controller: the full IEEE 1149.1 16-state TAP FSM plus an IR_WIDTH-bit instruction register, built-in IDCODE and BYPASS data registers, and decode of N_USER user data-register selects. It sits between the JTAG pins and the user DR chains (AXI access registers). It supplies TDO muxing and capture/shift/update strobes so user DRs hold no TAP state of their own.

## Interface
- IR_WIDTH, 4, instruction register width (≥2)
- IDCODE_VAL, 32'h1000_0001, value captured by IDCODE; bit 0 must be 1
- IR_IDCODE, 4'h1, IDCODE opcode; also the TLR reset instruction
- IR_BYPASS, all ones, BYPASS opcode
- N_USER, 2, number of user DR selects (1..8)
- USER_IR_BASE, 4'h2, opcode of user DR 0; user k = USER_IR_BASE+k
- tck  in  1  JTAG clock; all state on rising edge
- trst  in  1  asynchronous, active-high reset
- tms  in  1  test mode select
- tdi  in  1  test data in
- tdo  out  1  test data out (combinational mux, see Operation)
- tdo_en  out  1  high in SHIFT_DR/SHIFT_IR
- tap_state  out  tap_ctrl_fsm_t  current FSM state
- ir_o  out  IR_WIDTH  active instruction
- user_sel  out  N_USER  one-hot decode of ir_o onto user DRs
- capture_dr, shift_dr, update_dr  out  1 each  high while tap_state is CAPTURE_DR / SHIFT_DR / UPDATE_DR
- user_tdo  in  N_USER  bit 0 of each user DR shift register

## Operation
- FSM: standard 1149.1 transitions on tms. Five consecutive tms=1 reach TEST_LOGIC_RESET from any state. Illegal encodings go to TEST_LOGIC_RESET.
- IR shift register ir_sr:
  - CAPTURE_IR: load {0…0, 2'b01}.
  - SHIFT_IR: ir_sr <= {tdi, ir_sr[W-1:1]}.
  - UPDATE_IR: ir_o <= ir_sr.
  - TEST_LOGIC_RESET: ir_o <= IR_IDCODE.
- Decode:
  - ir_o == IR_IDCODE selects IDCODE.
  - USER_IR_BASE ≤ ir_o < USER_IR_BASE+N_USER selects user_sel[ir_o-USER_IR_BASE].
  - Any other value, including IR_BYPASS, selects BYPASS.
  - user_sel is zero unless a user DR is selected.
- IDCODE DR, 32 bits:
  - CAPTURE_DR: load IDCODE_VAL.
  - SHIFT_DR: shift right, tdi into bit 31.
- BYPASS DR, 1 bit:
  - CAPTURE_DR: load 0.
  - SHIFT_DR: load tdi.
- Built-in DRs change only when selected.
- tdo source:
  - SHIFT_IR: ir_sr[0].
  - SHIFT_DR: bit 0 of the selected DR (idcode_sr[0], bypass_ff or user_tdo[k]).
  - Any other state: 0.
- External pad logic retimes tdo on the falling edge.

## Timing
- Reset (trst=1, async), all registers:
  - tap_state=TEST_LOGIC_RESET, ir_o=IR_IDCODE, ir_sr=1.
  - idcode_sr=IDCODE_VAL, bypass_ff=0.
- Reset output values:
  - tdo=0, tdo_en=0, user_sel=0.
  - capture_dr=shift_dr=update_dr=0.
- trst mid-shift aborts immediately. Partially shifted IR data is discarded, and ir_o reads IR_IDCODE in the same cycle.
- Latency:
  - Strobes and tdo_en are decoded from the registered state, with zero cycles after the state edge.
  - A new ir_o is visible from the rising edge leaving UPDATE_IR.
  - user_sel follows ir_o combinationally.
- Shift timing:
  - Each SHIFT edge samples tdi and advances the chain.
  - The edge that exits SHIFT (tms=1) also shifts; tdo reflects the post-edge register.
- BYPASS: a tdi bit shifted in SHIFT_DR appears on tdo one tck later.
- Paths through PAUSE_DR/PAUSE_IR and back via EXIT2 keep shift register contents intact.

## Test plan
- Reset, IDCODE read:
  - Stimulus: trst pulse; tms 0,1,0,0; 32 SHIFT_DR cycles, the last with tms=1.
  - Response: tdo yields 32'h1000_0001 LSB first; tap_state=EXIT1_DR.
- TLR from any state: from SHIFT_IR, tms=1 for 5 cycles → TEST_LOGIC_RESET, ir_o=4'h1.
- IR capture and BYPASS:
  - Stimulus: shift IR 4'hF into SHIFT_IR.
  - Response: first 4 tdo bits are 1,0,0,0. After UPDATE_IR, ir_o=4'hF and user_sel=0.
  - Follow-up: in SHIFT_DR, tdi 1,0,1,1 → tdo 0,1,0,1.
- User DR select:
  - Stimulus: load IR 4'h3.
  - Response: user_sel=2'b10. In SHIFT_DR, tdo mirrors user_tdo[1] and shift_dr=1. Exiting pulses update_dr for exactly one cycle.
- Pause path: shift 10 IDCODE bits, go to PAUSE_DR for 3 cycles, resume via EXIT2_DR → remaining 22 bits continue without loss or repetition.
- Async reset mid-operation: assert trst in SHIFT_IR between edges → tap_state=TEST_LOGIC_RESET, ir_o=4'h1 and tdo_en=0 immediately, without a tck edge.
